// File: rtl/pipereg_pkg.sv
// -----------------------------------------------------------------------------
// pipereg_pkg
// Shared definitions for the pipereg_flow register chain.
//   PIPE_COLLAPSE / PIPE_GLOBAL : values for the COLLAPSE parameter.
//   clog2()                     : ceiling log2, used to size the occupancy count.
// -----------------------------------------------------------------------------
package pipereg_pkg;

   localparam int PIPE_COLLAPSE = 1;  // per-stage ready, bubbles squeezed out
   localparam int PIPE_GLOBAL   = 0;  // whole chain stalls with the output stage

   // Number of bits needed to encode values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipereg_flow_stage.sv
// -----------------------------------------------------------------------------
// pipereg_flow_stage
// One register slot of the pipereg_flow chain: a valid bit plus payload.
//   clk, resetn : clock, synchronous active-low reset
//   i_en        : load from the source this edge (otherwise hold)
//   i_kill      : empty the slot this edge, overriding load and hold
//   i_src_v/d   : source entry (the previous stage, or the gated input)
//   o_v, o_d    : current slot contents
// The source data is already zero whenever its valid is low, so the slot keeps
// the "invalid implies zero data" property without gating here.
// -----------------------------------------------------------------------------
module pipereg_flow_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_en,
   input  logic             i_kill,
   input  logic             i_src_v,
   input  logic [WIDTH-1:0] i_src_d,
   output logic             o_v,
   output logic [WIDTH-1:0] o_d
);

   logic             r_v;
   logic [WIDTH-1:0] r_d;

   // NOTE: non-blocking (<=) so every stage samples its neighbour's pre-edge
   // value; blocking here would let an entry race through several stages.
   always_ff @(posedge clk) begin
      if (!resetn || i_kill) begin
         // NOTE: the payload is cleared along with valid, not just valid:
         // downstream decode reads the data without qualifying it.
         r_v <= 1'b0;
         r_d <= '0;
      end else if (i_en) begin
         r_v <= i_src_v;
         r_d <= i_src_d;
      end
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/pipereg_flow.sv
// -----------------------------------------------------------------------------
// pipereg_flow
// DEPTH-stage, WIDTH-bit pipeline register chain with valid/ready flow control,
// per-stage squash, flush and optional bubble collapsing.
//   clk, resetn  : clock, synchronous active-low reset
//   in_valid/in_data/in_ready    : upstream handshake into stage 0
//   out_valid/out_data/out_ready : downstream handshake from stage DEPTH-1
//   squash[i]    : empty stage i after this edge (destination slot only)
//   flush        : squash every stage
//   occupancy    : number of valid stages (combinational)
// Squash/flush only act on the registers, never on ready, so there is no
// combinational path from them to any output.
// -----------------------------------------------------------------------------
module pipereg_flow
   import pipereg_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 3,
   parameter int COLLAPSE = PIPE_COLLAPSE,
   parameter int CNTW     = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic [DEPTH-1:0] squash,
   input  logic             flush,
   output logic [CNTW-1:0]  occupancy
);

   localparam bit MODE_COLLAPSE = (COLLAPSE == PIPE_COLLAPSE);

   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_src_v;
   logic [DEPTH-1:0] w_kill;
   logic [WIDTH-1:0] w_d     [DEPTH];
   logic [WIDTH-1:0] w_src_d [DEPTH];
   logic             w_tail_full;

   // Ready chain. The recursive form rdy[i] = !v[i] | rdy[i+1] is unrolled to
   // "out_ready, or some stage from i to the output is empty", which reads only
   // the registered valids and so avoids a self-referencing vector.
   // NOTE: every always_comb target gets a default before the loop, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_rdy       = '0;
      w_tail_full = 1'b1;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_tail_full = w_tail_full & w_v[i];
         if (MODE_COLLAPSE) begin
            w_rdy[i] = out_ready | !w_tail_full;
         end else begin
            w_rdy[i] = out_ready | !w_v[DEPTH-1];
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         // Gate the payload so an invalid input never lands non-zero data.
         assign w_src_v[i] = in_valid;
         assign w_src_d[i] = in_valid ? in_data : '0;
      end else begin : g_body
         assign w_src_v[i] = w_v[i-1];
         assign w_src_d[i] = w_d[i-1];
      end

      assign w_kill[i] = squash[i] | flush;

      pipereg_flow_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk     (clk),
         .resetn  (resetn),
         .i_en    (w_rdy[i]),
         .i_kill  (w_kill[i]),
         .i_src_v (w_src_v[i]),
         .i_src_d (w_src_d[i]),
         .o_v     (w_v[i]),
         .o_d     (w_d[i])
      );
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = w_v[DEPTH-1];
   assign out_data  = w_d[DEPTH-1];

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + CNTW'(w_v[i]);
      end
   end

endmodule

// File: tb/tb_pipereg_flow.sv
// -----------------------------------------------------------------------------
// tb_pipereg_flow
// Two DEPTH=3, WIDTH=8 instances: dut_c in collapse mode, dut_g in global-stall
// mode. Each vector drives inputs after the falling edge, compares in_ready,
// out_valid, out_data and occupancy just before the next rising edge (i.e. the
// state left by the previous edge), then lets the rising edge act.
// -----------------------------------------------------------------------------
module tb_pipereg_flow;
   import pipereg_pkg::*;

   typedef struct {
      logic       iv;
      logic [7:0] din;
      logic       ordy;
      logic [2:0] sq;
      logic       fl;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [1:0] e_occ;
   } vec_t;

   logic clk;
   logic resetn;

   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
   logic [7:0] c_in_data, c_out_data;
   logic [2:0] c_squash;
   logic [1:0] c_occ;

   logic       g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_flush;
   logic [7:0] g_in_data, g_out_data;
   logic [2:0] g_squash;
   logic [1:0] g_occ;

   int n_checks = 0;
   int n_pass   = 0;

   vec_t tbl_c[$];
   vec_t tbl_g[$];

   pipereg_flow #(.WIDTH(8), .DEPTH(3), .COLLAPSE(PIPE_COLLAPSE)) dut_c (
      .clk(clk), .resetn(resetn),
      .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
      .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
      .squash(c_squash), .flush(c_flush), .occupancy(c_occ)
   );

   pipereg_flow #(.WIDTH(8), .DEPTH(3), .COLLAPSE(PIPE_GLOBAL)) dut_g (
      .clk(clk), .resetn(resetn),
      .in_valid(g_in_valid), .in_data(g_in_data), .in_ready(g_in_ready),
      .out_valid(g_out_valid), .out_data(g_out_data), .out_ready(g_out_ready),
      .squash(g_squash), .flush(g_flush), .occupancy(g_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [7:0] din, input logic ordy,
                               input logic [2:0] sq, input logic fl,
                               input logic e_ir, input logic e_ov,
                               input logic [7:0] e_od, input logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.din = din; v.ordy = ordy; v.sq = sq; v.fl = fl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic apply(input vec_t v, input bit use_g, input string tag);
      logic       ir, ov;
      logic [7:0] od;
      logic [1:0] occ;
      @(negedge clk);
      if (use_g) begin
         g_in_valid = v.iv; g_in_data = v.din; g_out_ready = v.ordy;
         g_squash = v.sq; g_flush = v.fl;
      end else begin
         c_in_valid = v.iv; c_in_data = v.din; c_out_ready = v.ordy;
         c_squash = v.sq; c_flush = v.fl;
      end
      #1;
      ir  = use_g ? g_in_ready  : c_in_ready;
      ov  = use_g ? g_out_valid : c_out_valid;
      od  = use_g ? g_out_data  : c_out_data;
      occ = use_g ? g_occ       : c_occ;
      check({tag, " in_ready"},  32'(ir),  32'(v.e_ir));
      check({tag, " out_valid"}, 32'(ov),  32'(v.e_ov));
      check({tag, " out_data"},  32'(od),  32'(v.e_od));
      check({tag, " occupancy"}, 32'(occ), 32'(v.e_occ));
   endtask

   initial begin
      //                iv  din    ordy sq    fl  | ir  ov  od     occ
      // streaming latency and order
      tbl_c.push_back(mk(1, 8'h11, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(1, 8'h22, 1, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(1, 8'h33, 1, 3'b000, 0,  1, 0, 8'h00, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h11, 2'd3));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h22, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h33, 2'd1));
      // collapse fill under stall: A, bubble, B, C, then D held off
      tbl_c.push_back(mk(1, 8'h0A, 0, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(0, 8'h00, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(1, 8'h0B, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(1, 8'h0C, 0, 3'b000, 0,  1, 1, 8'h0A, 2'd2));
      tbl_c.push_back(mk(1, 8'h0D, 0, 3'b000, 0,  0, 1, 8'h0A, 2'd3));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h0A, 2'd3));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h0B, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h0C, 2'd1));
      // squash stage 1 while 0x22 moves into it, 0x33 accepted alongside
      tbl_c.push_back(mk(1, 8'h11, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(1, 8'h22, 1, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(1, 8'h33, 1, 3'b010, 0,  1, 0, 8'h00, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h11, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h33, 2'd1));
      // squash[0] with accept of 0x44: handshake completes, entry dropped
      tbl_c.push_back(mk(1, 8'h44, 1, 3'b001, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      // fill under stall, then flush: out_valid still 1 in the flush cycle
      tbl_c.push_back(mk(1, 8'h55, 0, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(1, 8'h66, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(1, 8'h77, 0, 3'b000, 0,  1, 0, 8'h00, 2'd2));
      tbl_c.push_back(mk(0, 8'h00, 0, 3'b000, 1,  0, 1, 8'h55, 2'd3));
      tbl_c.push_back(mk(0, 8'h00, 0, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      // output transfer coincident with squash[2]
      tbl_c.push_back(mk(1, 8'h88, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b100, 0,  1, 1, 8'h88, 2'd1));
      tbl_c.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));

      // global stall: same A, bubble, B, C stimulus; bubble is preserved
      tbl_g.push_back(mk(1, 8'h0A, 0, 3'b000, 0,  1, 0, 8'h00, 2'd0));
      tbl_g.push_back(mk(0, 8'h00, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_g.push_back(mk(1, 8'h0B, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1));
      tbl_g.push_back(mk(1, 8'h0C, 0, 3'b000, 0,  0, 1, 8'h0A, 2'd2));
      tbl_g.push_back(mk(1, 8'h0C, 1, 3'b000, 0,  1, 1, 8'h0A, 2'd2));
      tbl_g.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd2));
      tbl_g.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h0B, 2'd2));
      tbl_g.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 1, 8'h0C, 2'd1));
      tbl_g.push_back(mk(0, 8'h00, 1, 3'b000, 0,  1, 0, 8'h00, 2'd0));

      resetn = 1'b0;
      c_in_valid = 0; c_in_data = '0; c_out_ready = 1; c_squash = '0; c_flush = 0;
      g_in_valid = 0; g_in_data = '0; g_out_ready = 1; g_squash = '0; g_flush = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      foreach (tbl_c[i]) apply(tbl_c[i], 1'b0, $sformatf("c%0d", i));

      // reset with a full pipe and a live input: everything cleared, no drain
      apply(mk(1, 8'h91, 0, 3'b000, 0,  1, 0, 8'h00, 2'd0), 1'b0, "rst fill0");
      apply(mk(1, 8'h92, 0, 3'b000, 0,  1, 0, 8'h00, 2'd1), 1'b0, "rst fill1");
      apply(mk(1, 8'h93, 0, 3'b000, 0,  1, 0, 8'h00, 2'd2), 1'b0, "rst fill2");
      apply(mk(1, 8'h94, 0, 3'b000, 0,  0, 1, 8'h91, 2'd3), 1'b0, "rst full");
      @(negedge clk);
      resetn = 1'b0;
      c_in_valid = 1'b1; c_in_data = 8'hFF;
      @(negedge clk);
      resetn = 1'b1;
      c_in_valid = 1'b0; c_in_data = 8'h00;
      #1;
      check("rst occupancy", 32'(c_occ),       32'd0);
      check("rst out_valid", 32'(c_out_valid), 32'd0);
      check("rst out_data",  32'(c_out_data),  32'd0);
      check("rst in_ready",  32'(c_in_ready),  32'd1);

      foreach (tbl_g[i]) apply(tbl_g[i], 1'b1, $sformatf("g%0d", i));

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
